mx_matrix_cat_n: RTL
====================

// Module: mx_matrix_cat_n
// PURPOSE
//  Streaming MXInt concat along last dim (torch.cat(dim=-1)) of NUM_INPUTS matrices, each with its own column count.
//  Inputs stream row-major in blocks of BLOCK_SIZE mantissas with one shared exponent.
//  Output interleaves rows: row r = in0 blocks, then in1 blocks, ..., then in(N-1) blocks, then row r+1.
//  Sits between MX producers (attention heads, GNN aggregators) and downstream MX linear layers; precision is already uniform.
// PARAMETERS
//  NUM_INPUTS      2       number of concatenated input streams (>=2)
//  MWIDTH          8       mantissa width, all ports
//  EWIDTH          8       shared exponent width, all ports
//  PARALLELISM_0   1       block rows; BLOCK_SIZE = PARALLELISM_0*PARALLELISM_1
//  PARALLELISM_1   1       block columns
//  ROW_BLOCKS      1       block rows per tensor (same for all inputs)
//  COL_BLOCKS      {16'd1,16'd1}  packed NUM_INPUTS x 16b; entry i = column blocks per row of input i (>=1)
// PORTS
//  clk               in   1                      clock, rising edge
//  rst               in   1                      async reset, ACTIVE-LOW (asserted when 0)
//  mdata_in          in   MWIDTH x [N][BLOCK]    unpacked per-input mantissa blocks
//  edata_in          in   EWIDTH x [N]           per-input shared exponent
//  data_in_valid     in   N                      per-input valid
//  data_in_ready     out  N                      per-input ready
//  mdata_out_0       out  MWIDTH x [BLOCK]       output mantissa block
//  edata_out_0       out  EWIDTH                 output exponent
//  data_out_0_valid  out  1                      output valid
//  data_out_0_ready  in   1                      output ready
//  data_out_0_last   out  1                      high on final block of the whole concatenated tensor
//  data_out_0_eor    out  1                      high on final block of each output row
// BEHAVIOUR
//  Reset (rst=0, async): sel_r=0, col_r=0, row_r=0, out_valid=0, mdata_out_0/edata_out_0=0, last/eor=0, all data_in_ready=0 while held.
//  State: sel_r [clog2(N)], col_r [16], row_r [clog2(ROW_BLOCKS)+1]; no other state besides output register.
//  Output stage = one pipeline register: accept = !data_out_0_valid || data_out_0_ready.
//  data_in_ready[i] = accept && (i==sel_r) && !rst_asserted; all other readies 0 (no FIFOs, no reordering).
//  Beat accepted when data_in_valid[sel_r] && data_in_ready[sel_r]: register mdata/edata of sel_r, set out_valid next cycle.
//  Latency 1 cycle input-accept -> data_out_0_valid; full throughput 1 block/cycle under continuous ready.
//  If accept && no input beat: out_valid clears when data_out_0_ready consumes current beat.
//  Output held stable (data, last, eor) while valid && !ready.
//  Counter advance only on accepted beat:
//   col_r == COL_BLOCKS[sel_r]-1 -> col_r=0, sel_r++; else col_r++.
//   sel_r == N-1 at column wrap -> sel_r=0, eor=1 on that beat; row_r++.
//   row_r == ROW_BLOCKS-1 at row wrap -> row_r=0, last=1 on that beat; next tensor starts at in0 row 0 immediately.
//  Exponents passed unchanged per block (MX blocks self-describing; no re-alignment).
//  Valids on non-selected inputs ignored; their data may change freely.
//  Reset mid-tensor: partial output beat discarded, counters zero, next accepted beat is in0 row0 col0.
//  Elaboration asserts: NUM_INPUTS>=2, every COL_BLOCKS entry >=1, ROW_BLOCKS>=1.
// TESTING
//  N=2, COL=[1,1], ROW=2, BLOCK=1, in0=1,2 in1=5,6, ready=1 -> out 1,5,2,6; eor on 5,6; last on 6.
//  N=3, COL=[2,1,3], ROW=1, in0=A0,A1 in1=B0 in2=C0..C2 -> out A0 A1 B0 C0 C1 C2; last on C2 only.
//  Same cfg, data_out_0_ready toggles 1010..., random valid gaps -> identical ordered stream, no drop/dup, data stable while stalled.
//  in1 valid held high from cycle 0 while sel_r=0 -> data_in_ready[1]=0 until in0 row block completes; in1 beat not consumed early.
//  rst pulled low after 3 of 6 beats, released -> outputs zero immediately, valid=0; restart emits first block from in0 row 0.
//  BLOCK=4 (P0=2,P1=2), EWIDTH=8, edata in0=0x7F in1=0x80 -> each output block carries its source exponent unchanged, 4 lanes intact.

Source files
------------

// File: rtl/mx_matrix_cat_n.sv
// Streaming MXInt concat along the last dim: rows are rebuilt as in0 blocks, in1 blocks, ... per row.
// One output register (1-cycle latency, full throughput); only the selected input sees ready, others stall.
module mx_matrix_cat_n #(
   parameter int NUM_INPUTS    = 2,
   parameter int MWIDTH        = 8,
   parameter int EWIDTH        = 8,
   parameter int PARALLELISM_0 = 1,
   parameter int PARALLELISM_1 = 1,
   parameter int ROW_BLOCKS    = 1,
   parameter logic [NUM_INPUTS*16-1:0] COL_BLOCKS = {16'd1, 16'd1},
   localparam int BLOCK_SIZE   = PARALLELISM_0 * PARALLELISM_1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [MWIDTH-1:0]     mdata_in [NUM_INPUTS][BLOCK_SIZE],
   input  logic [EWIDTH-1:0]     edata_in [NUM_INPUTS],
   input  logic [NUM_INPUTS-1:0] data_in_valid,
   output logic [NUM_INPUTS-1:0] data_in_ready,
   output logic [MWIDTH-1:0]     mdata_out_0 [BLOCK_SIZE],
   output logic [EWIDTH-1:0]     edata_out_0,
   output logic                  data_out_0_valid,
   input  logic                  data_out_0_ready,
   output logic                  data_out_0_last,
   output logic                  data_out_0_eor
);
   localparam int SELW = $clog2(NUM_INPUTS);
   localparam int ROWW = $clog2(ROW_BLOCKS) + 1;

   if (NUM_INPUTS < 2) begin : g_chk_inputs
      $error("mx_matrix_cat_n: NUM_INPUTS must be >= 2");
   end
   if (ROW_BLOCKS < 1) begin : g_chk_rows
      $error("mx_matrix_cat_n: ROW_BLOCKS must be >= 1");
   end
   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_chk_cols
      if (COL_BLOCKS[g*16 +: 16] == 16'd0) begin : g_bad
         $error("mx_matrix_cat_n: COL_BLOCKS entries must be >= 1");
      end
   end

   logic [SELW-1:0]   sel_q, sel_d;
   logic [15:0]       col_q, col_d;
   logic [ROWW-1:0]   row_q, row_d;
   logic              out_valid_q, out_valid_d;
   logic              last_q, last_d;
   logic              eor_q, eor_d;
   logic [EWIDTH-1:0] edata_q, edata_d;
   logic [MWIDTH-1:0] mdata_q [BLOCK_SIZE];
   logic [MWIDTH-1:0] mdata_d [BLOCK_SIZE];

   logic              accept;
   logic              beat;
   logic              sel_vld;
   logic [EWIDTH-1:0] sel_e;
   logic [MWIDTH-1:0] sel_m [BLOCK_SIZE];
   logic [15:0]       col_lim;
   logic              col_wrap, sel_wrap, row_wrap;

   always_comb begin
      accept  = !out_valid_q || data_out_0_ready;
      sel_vld = 1'b0;
      sel_e   = '0;
      sel_m   = '{default: '0};
      col_lim = 16'd1;
      // Explicit mux keeps non-power-of-two input counts free of out-of-range indexing.
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (sel_q == SELW'(i)) begin
            sel_vld = data_in_valid[i];
            sel_m   = mdata_in[i];
            sel_e   = edata_in[i];
            col_lim = COL_BLOCKS[i*16 +: 16];
         end
      end
      beat     = accept && sel_vld && rst;
      col_wrap = (col_q == col_lim - 16'd1);
      sel_wrap = (sel_q == SELW'(NUM_INPUTS - 1));
      row_wrap = (row_q == ROWW'(ROW_BLOCKS - 1));

      sel_d       = sel_q;
      col_d       = col_q;
      row_d       = row_q;
      out_valid_d = out_valid_q;
      last_d      = last_q;
      eor_d       = eor_q;
      edata_d     = edata_q;
      mdata_d     = mdata_q;

      if (accept) begin
         out_valid_d = beat;
      end
      if (beat) begin
         mdata_d = sel_m;
         edata_d = sel_e;
         eor_d   = col_wrap && sel_wrap;
         last_d  = col_wrap && sel_wrap && row_wrap;
         if (col_wrap) begin
            col_d = 16'd0;
            if (sel_wrap) begin
               sel_d = '0;
               row_d = row_wrap ? '0 : row_q + ROWW'(1);
            end else begin
               sel_d = sel_q + SELW'(1);
            end
         end else begin
            col_d = col_q + 16'd1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         data_in_ready[i] = accept && (sel_q == SELW'(i)) && rst;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q       <= '0;
         col_q       <= '0;
         row_q       <= '0;
         out_valid_q <= 1'b0;
         last_q      <= 1'b0;
         eor_q       <= 1'b0;
         edata_q     <= '0;
         mdata_q     <= '{default: '0};
      end else begin
         sel_q       <= sel_d;
         col_q       <= col_d;
         row_q       <= row_d;
         out_valid_q <= out_valid_d;
         last_q      <= last_d;
         eor_q       <= eor_d;
         edata_q     <= edata_d;
         mdata_q     <= mdata_d;
      end
   end

   assign mdata_out_0      = mdata_q;
   assign edata_out_0      = edata_q;
   assign data_out_0_valid = out_valid_q;
   assign data_out_0_last  = last_q;
   assign data_out_0_eor   = eor_q;
endmodule
